// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_FWD = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SUB = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle ALU operations with carry/borrow. Multi-cycle opcodes pass
// operand A through, which is exactly the zero-amount shift result.
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res   = a;
        carry = 1'b0;
        case (op_e'(op))
            OP_FWD: res = b;
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
            end
            default: res = a;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops finish on the accept edge; shifts run one
// bit per cycle and multiply is a WIDTH-cycle shift-add, all behind a ready/valid FSM.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY
);

    state_e           state, state_nxt;
    logic             init_q;
    op_e              op_q;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q, result_q;
    logic [SHW-1:0]   cnt_q;
    logic             carry_q;

    logic             accept, seq_now, last;
    op_e              op_in;
    logic [SHW-1:0]   shamt_in;
    logic [WIDTH-1:0] cu_res, sh_step, mul_step;
    logic             cu_carry;

    alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
        .op    (SELECT),
        .a     (DATA1),
        .b     (DATA2),
        .res   (cu_res),
        .carry (cu_carry)
    );

    // init_q keeps IN_READY low until the first edge after reset release
    assign IN_READY  = (state == IDLE) && init_q;
    assign OUT_VALID = (state == DONE);
    assign RESULT    = result_q;
    assign ZERO      = (result_q == '0);
    assign CARRY     = carry_q;

    assign accept   = IN_VALID && IN_READY;
    assign op_in    = op_e'(SELECT);
    assign shamt_in = DATA2[SHW-1:0];
    assign seq_now  = (op_in == OP_MUL) ||
                      (((op_in == OP_SLL) || (op_in == OP_SRA)) && (shamt_in != '0));
    assign last     = (cnt_q == '0);

    assign sh_step  = (op_q == OP_SLL) ? (opa_q << 1) : {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
    assign mul_step = acc_q + (opb_q[0] ? opa_q : '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = seq_now ? EXEC : DONE;
            EXEC:    if (last) state_nxt = DONE;
            DONE:    if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            init_q   <= 1'b0;
            op_q     <= OP_FWD;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (accept) begin
                op_q  <= op_in;
                opa_q <= DATA1;
                opb_q <= DATA2;
                acc_q <= '0;
                // counter holds remaining EXEC cycles minus one
                cnt_q <= (op_in == OP_MUL) ? SHW'(WIDTH - 1) : shamt_in - SHW'(1);
                if (!seq_now) begin
                    result_q <= cu_res;
                    carry_q  <= cu_carry;
                end
            end else if (state == EXEC) begin
                cnt_q <= cnt_q - SHW'(1);
                if (op_q == OP_MUL) begin
                    acc_q <= mul_step;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                end else begin
                    opa_q <= sh_step;
                end
                if (last) begin
                    result_q <= (op_q == OP_MUL) ? mul_step : sh_step;
                    carry_q  <= 1'b0;
                end
            end
        end
    end

endmodule
